// File: rtl/offchip_link_pkg.sv
// Shared definitions for the off-chip nibble link.
// Contents:
//   LNK_W, BYTE_W              link word and byte widths
//   DEFAULT_DEPTH              default receive word-FIFO depth
//   DEFAULT_CREDIT_GRAN        default words returned per credit pulse
//   lnk_pair_to_byte(a, b)     reassembles an even/odd word pair into a byte.
//                              The transmitter's split logic uses the same
//                              mapping, so both ends agree on it.
package offchip_link_pkg;

  localparam int LNK_W               = 4;
  localparam int BYTE_W              = 8;
  localparam int DEFAULT_DEPTH       = 8;
  localparam int DEFAULT_CREDIT_GRAN = 4;

  // Bit mapping of the two words:
  //   even word a = {b5,b4,b1,b0}
  //   odd word  b = {b7,b6,b3,b2}
  function automatic logic [BYTE_W-1:0] lnk_pair_to_byte(
    input logic [LNK_W-1:0] a,
    input logic [LNK_W-1:0] b
  );
    return {b[3:2], a[3:2], b[1:0], a[1:0]};
  endfunction

endpackage

// File: rtl/offchip_rx_word_fifo.sv
// Word FIFO for the off-chip link receiver.
// It has one write port and a two-word read port. A pop always removes the
// pair at the head of the FIFO.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   push, push_data     write one word. The caller asserts push only when
//                       full is low.
//   pop                 remove the two head words. The caller asserts pop only
//                       when count >= 2.
//   rd_a, rd_b          head word (rptr) and the word after it (rptr+1)
//   count, full         occupancy before the edge
module offchip_rx_word_fifo
  import offchip_link_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [LNK_W-1:0] push_data,
  input  logic             pop,
  output logic [LNK_W-1:0] rd_a,
  output logic [LNK_W-1:0] rd_b,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [LNK_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rptr_b;
  logic [CW-1:0]    count_next;

  // DEPTH is a power of 2, so the pointers wrap on natural overflow.
  assign rptr_b = rptr + AW'(1);
  assign rd_a   = mem[rptr];
  assign rd_b   = mem[rptr_b];
  assign full   = (count == CW'(DEPTH));

  always_comb begin
    count_next = count;
    if (push) count_next = count_next + CW'(1);
    if (pop)  count_next = count_next - CW'(2);
  end

  // The storage array is not reset. A word can be read only after its
  // pointer has been covered by a push.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(2);
      count <= count_next;
    end
  end

endmodule

// File: rtl/offchip_link_rx.sv
// Receive end of the off-chip nibble link.
// Link words are written into a word FIFO. Each even/odd pair is rebuilt into
// a byte and held in a registered valid/ready output stage. Every two popped
// pairs worth of words returns credit to the transmitter: one lnk_credit pulse
// means CREDIT_GRAN words are free again.
// Optional feature: define OFFCHIP_RX_PARITY_EN to add the lnk_par input and
// the sticky par_err output. Parity is even over {lnk_data, lnk_par}.
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   lnk_valid, lnk_data  incoming link word. The link has no backpressure.
//   lnk_credit           one-cycle credit-return pulse
//   data_out, valid_out  reassembled byte
//   ready                consumer accepts the byte when valid_out && ready
//   ovf_err              sticky flag: a word arrived while the FIFO was full
//   lnk_par, par_err     parity bit and sticky parity error (optional)
// Handshake: a byte transfers on any edge where valid_out && ready.
// data_out stays stable while valid_out && !ready.
module offchip_link_rx
  import offchip_link_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int CREDIT_GRAN = DEFAULT_CREDIT_GRAN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lnk_valid,
  input  logic [LNK_W-1:0]  lnk_data,
`ifdef OFFCHIP_RX_PARITY_EN
  input  logic              lnk_par,
  output logic              par_err,
`endif
  output logic              lnk_credit,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready,
  output logic              ovf_err
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int ACCW = $clog2(CREDIT_GRAN) + 1;

  logic [LNK_W-1:0] rd_a;
  logic [LNK_W-1:0] rd_b;
  logic [CW-1:0]    count;
  logic             full;
  logic             push;
  logic             pop;
  logic [ACCW-1:0]  acc;
  logic [ACCW-1:0]  acc_sum;
  logic             credit_fire;

  // Push and pop both look at the occupancy before the edge. A word that
  // arrives in the same cycle as a pop cannot be part of that pop, and a word
  // that arrives while the FIFO is full is dropped even if a pop frees space
  // on the same edge.
  assign push = lnk_valid && !full;
  assign pop  = (count >= CW'(2)) && (!valid_out || ready);

  // The accumulator never holds more than CREDIT_GRAN-2 between pops, so
  // acc + 2 still fits in ACCW bits.
  assign acc_sum     = acc + ACCW'(2);
  assign credit_fire = (acc_sum >= ACCW'(CREDIT_GRAN));

  offchip_rx_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (lnk_data),
    .pop       (pop),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .count     (count),
    .full      (full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      lnk_credit <= 1'b0;
      acc        <= '0;
      ovf_err    <= 1'b0;
    end else begin
      if (pop) begin
        data_out  <= lnk_pair_to_byte(rd_a, rd_b);
        valid_out <= 1'b1;
      end else if (ready) begin
        valid_out <= 1'b0;
      end
      lnk_credit <= pop && credit_fire;
      if (pop) acc <= credit_fire ? (acc_sum - ACCW'(CREDIT_GRAN)) : acc_sum;
      if (lnk_valid && full) ovf_err <= 1'b1;
    end
  end

`ifdef OFFCHIP_RX_PARITY_EN
  // A word with bad parity is still stored. Only accepted words are checked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err <= 1'b0;
    end else if (push && (^{lnk_data, lnk_par})) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule
